// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with valid/ready handshake and optional skid entry
module pipe_stage_reg #(
    parameter int WB_W   = 2,
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int SKID   = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [WB_W-1:0]   WB_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [RD_W-1:0]   rd_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [WB_W-1:0]   WB_o,
    output logic [DATA_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic [RD_W-1:0]   rd_o,
    output logic [1:0]        count_o
);

    // Payload is handled as one flat word so main/skid moves are single assignments.
    localparam int PL_W = WB_W + 2 * DATA_W + RD_W;

    // State encoding equals the number of held entries, so count_o is the state register.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [PL_W-1:0] main_q, main_d;
    logic [PL_W-1:0] skid_q, skid_d;
    logic            valid_q, valid_d;
    logic            ready_q, ready_d;

    logic [PL_W-1:0] in_pl;
    logic            in_fire;
    logic            out_fire;

    assign in_pl    = {WB_i, addr_i, data_i, rd_i};
    assign in_fire  = valid_i & ready_o;
    assign out_fire = valid_q & ready_i;

    // Upstream ready: a flop with the skid entry, otherwise passes downstream ready through.
    generate
        if (SKID != 0) begin : g_ready_reg
            assign ready_o = ready_q;
        end else begin : g_ready_comb
            assign ready_o = ~valid_q | ready_i;
        end
    endgenerate

    // Next-state and payload movement for the EMPTY/ONE/TWO occupancy machine.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_d  = in_pl;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    // Output consumed and replaced in the same cycle: full throughput.
                    main_d = in_pl;
                end else if (in_fire && (SKID != 0)) begin
                    // Downstream stalled: park the new entry behind the output one.
                    skid_d  = in_pl;
                    state_d = ST_TWO;
                end else if (out_fire) begin
                    // Clearing main keeps the payload outputs zero while invalid.
                    main_d  = '0;
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    skid_d  = '0;
                    state_d = ST_ONE;
                end
            end
            default: begin
                main_d  = '0;
                skid_d  = '0;
                state_d = ST_EMPTY;
            end
        endcase
        valid_d = (state_d != ST_EMPTY);
        ready_d = (state_d != ST_TWO);
    end

    // State update: reset and flush both return to an empty, all-zero stage.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else if (flush_i) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign valid_o = valid_q;
    assign count_o = state_q;
    assign {WB_o, addr_o, data_o, rd_o} = main_q;

endmodule
